// File: rtl/systolic_feeder_pkg.sv
// Shared types and helpers for the systolic operand feeder.
// Optional macro FEEDER_OUTPUT_REG_EN (used in systolic_feeder.sv) adds an output register stage.
package systolic_feeder_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_N          = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READY  = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } feeder_state_e;

  // Number of STREAM cycles: t runs 0 .. 3N-3.
  function automatic int stream_len(input int n);
    return 3 * n - 2;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(3 * n);
  endfunction

  function automatic int lane_lsb(input int lane, input int data_width);
    return lane * data_width;
  endfunction

endpackage

// File: rtl/systolic_feeder_lane_sel.sv
// Skewed element selector for one edge lane: returns vec_i[t_i - lane_i] while it is
// inside the vector, otherwise zero.
module feeder_lane_sel
  import systolic_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N          = DEFAULT_N,
  parameter int CW         = cnt_width(DEFAULT_N)
) (
  input  logic [N*DATA_WIDTH-1:0] vec_i,
  input  logic [CW-1:0]           lane_i,
  input  logic [CW-1:0]           t_i,
  input  logic                    en_i,
  output logic [DATA_WIDTH-1:0]   elem_o
);

  logic [CW-1:0] idx_s;

  assign idx_s = t_i - lane_i;

  // Pick the element at offset t - lane; an out-of-range offset matches no k and stays zero.
  always_comb begin
    elem_o = '0;
    if (en_i && (t_i >= lane_i)) begin
      for (int k = 0; k < N; k++) begin
        if (idx_s == CW'(k)) begin
          elem_o = vec_i[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
        end
      end
    end else begin
      elem_o = '0;
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Loads A rows / B columns, then streams skewed operands into the PE grid edges.
// Macro FEEDER_OUTPUT_REG_EN registers lanes and acc_clear, delaying done by one cycle.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N          = DEFAULT_N
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N*DATA_WIDTH-1:0] a_row_i,
  input  logic [N*DATA_WIDTH-1:0] b_col_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic                    start_i,
  output logic [N*DATA_WIDTH-1:0] left_o,
  output logic [N*DATA_WIDTH-1:0] up_o,
  output logic                    acc_clear_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int CW = cnt_width(N);
  localparam int VW = N * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
  localparam logic [CW-1:0] LAST_T    = CW'(stream_len(N) - 1);

  feeder_state_e state_q;
  logic [CW-1:0] beat_q;
  logic [CW-1:0] t_q;
  logic          load_ready_q;
  logic          acc_clear_q;
  logic          busy_q;
  logic          done_q;

  logic [VW-1:0] a_buf_q [N];
  logic [VW-1:0] b_buf_q [N];

  logic          load_fire_d;
  logic          streaming_s;
  logic [VW-1:0] left_s;
  logic [VW-1:0] up_s;

  assign load_fire_d = (state_q == ST_IDLE) && load_ready_q && load_valid_i;
  assign streaming_s = (state_q == ST_STREAM);

  // Control FSM; status outputs are registered alongside the state they describe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      t_q          <= '0;
      load_ready_q <= 1'b1;
      acc_clear_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_fire_d) begin
            if (beat_q == LAST_BEAT) begin
              state_q      <= ST_READY;
              beat_q       <= '0;
              load_ready_q <= 1'b0;
            end else begin
              beat_q <= beat_q + CW'(1);
            end
          end
        end
        ST_READY: begin
          if (start_i) begin
            state_q     <= ST_CLEAR;
            acc_clear_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state_q     <= ST_STREAM;
          t_q         <= '0;
          acc_clear_q <= 1'b0;
        end
        ST_STREAM: begin
          if (t_q == LAST_T) begin
            state_q <= ST_DONE;
            t_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            t_q <= t_q + CW'(1);
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          beat_q       <= '0;
          done_q       <= 1'b0;
          load_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= ST_IDLE;
          beat_q       <= '0;
          t_q          <= '0;
          load_ready_q <= 1'b1;
          acc_clear_q  <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
        end
      endcase
    end
  end

  // Operand buffer: beat k holds A row k and B column k; contents need no reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N; k++) begin
      if (load_fire_d && (beat_q == CW'(k))) begin
        a_buf_q[k] <= a_row_i;
        b_buf_q[k] <= b_col_i;
      end
    end
  end

  // Left lane r walks along A row r; top lane c walks down B column c.
  for (genvar g = 0; g < N; g++) begin : g_lane
    feeder_lane_sel #(
      .DATA_WIDTH (DATA_WIDTH),
      .N          (N),
      .CW         (CW)
    ) u_left_sel (
      .vec_i  (a_buf_q[g]),
      .lane_i (CW'(g)),
      .t_i    (t_q),
      .en_i   (streaming_s),
      .elem_o (left_s[lane_lsb(g, DATA_WIDTH) +: DATA_WIDTH])
    );

    feeder_lane_sel #(
      .DATA_WIDTH (DATA_WIDTH),
      .N          (N),
      .CW         (CW)
    ) u_up_sel (
      .vec_i  (b_buf_q[g]),
      .lane_i (CW'(g)),
      .t_i    (t_q),
      .en_i   (streaming_s),
      .elem_o (up_s[lane_lsb(g, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

  assign load_ready_o = load_ready_q;

`ifdef FEEDER_OUTPUT_REG_EN
  logic [VW-1:0] left_q;
  logic [VW-1:0] up_q;
  logic          acc_clear_dly_q;
  logic          done_dly_q;
  logic          busy_dly_q;

  // Output stage: one cycle of latency on lanes, clear and done; busy stretches to cover it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      left_q          <= '0;
      up_q            <= '0;
      acc_clear_dly_q <= 1'b0;
      done_dly_q      <= 1'b0;
      busy_dly_q      <= 1'b0;
    end else begin
      left_q          <= left_s;
      up_q            <= up_s;
      acc_clear_dly_q <= acc_clear_q;
      done_dly_q      <= done_q;
      busy_dly_q      <= busy_q;
    end
  end

  assign left_o      = left_q;
  assign up_o        = up_q;
  assign acc_clear_o = acc_clear_dly_q;
  assign done_o      = done_dly_q;
  assign busy_o      = busy_q | busy_dly_q;
`else
  assign left_o      = left_s;
  assign up_o        = up_s;
  assign acc_clear_o = acc_clear_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench: directed N=2 stream with a 2x2 grid model, randomized N=4 streams,
// flow-control corner cases and mid-stream reset.
module tb_systolic_feeder;

  localparam int DW = 32;
  localparam int N4 = 4;
  localparam int N2 = 2;
`ifdef FEEDER_OUTPUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N4*DW-1:0] a4, b4, left4, up4;
  logic             lv4, lr4, st4, clr4, busy4, done4;
  logic [N2*DW-1:0] a2, b2, left2, up2;
  logic             lv2, lr2, st2, clr2, busy2, done2;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [DW-1:0] ma [N4][N4];
  logic [DW-1:0] mb [N4][N4];

  systolic_feeder #(.DATA_WIDTH(DW), .N(N4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .a_row_i(a4), .b_col_i(b4), .load_valid_i(lv4),
    .load_ready_o(lr4), .start_i(st4), .left_o(left4), .up_o(up4),
    .acc_clear_o(clr4), .busy_o(busy4), .done_o(done4)
  );

  systolic_feeder #(.DATA_WIDTH(DW), .N(N2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .a_row_i(a2), .b_col_i(b2), .load_valid_i(lv2),
    .load_ready_o(lr2), .start_i(st2), .left_o(left2), .up_o(up2),
    .acc_clear_o(clr2), .busy_o(busy2), .done_o(done2)
  );

  // 2x2 output-stationary PE grid fed by the N=2 feeder
  logic [DW-1:0] pa00, pa10, pb00, pb01;
  logic [DW-1:0] acc00, acc01, acc10, acc11;
  always @(posedge clk) begin
    pa00 <= left2[0 +: DW];
    pa10 <= left2[DW +: DW];
    pb00 <= up2[0 +: DW];
    pb01 <= up2[DW +: DW];
    acc00 <= clr2 ? '0 : acc00 + left2[0 +: DW] * up2[0 +: DW];
    acc01 <= clr2 ? '0 : acc01 + pa00 * up2[DW +: DW];
    acc10 <= clr2 ? '0 : acc10 + left2[DW +: DW] * pb00;
    acc11 <= clr2 ? '0 : acc11 + pa10 * pb01;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load4();
    for (int k = 0; k < N4; k++) begin
      for (int e = 0; e < N4; e++) begin
        a4[e*DW +: DW] = ma[k][e];
        b4[e*DW +: DW] = mb[e][k];
      end
      lv4 = 1'b1;
      tick();
    end
    lv4 = 1'b0;
  endtask

  task automatic test_reset();
    vec_cnt++;
    if ({lr4, clr4, busy4, done4} !== 4'b1000) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b want 1000", {lr4, clr4, busy4, done4});
    end
    vec_cnt++;
    if ({left4, up4} !== '0) begin
      err_cnt++;
      $display("FAIL reset_lanes: got %h want 0", {left4, up4});
    end
  endtask

  task automatic test_directed_n2();
    logic [N2*DW-1:0] tl [4];
    logic [N2*DW-1:0] tu [4];
    logic [N2*DW-1:0] el, eu;
    logic [3:0]       ec;
    int               t;
    tl[0] = {32'd0, 32'd1}; tl[1] = {32'd3, 32'd2}; tl[2] = {32'd4, 32'd0}; tl[3] = '0;
    tu[0] = {32'd0, 32'd5}; tu[1] = {32'd6, 32'd7}; tu[2] = {32'd8, 32'd0}; tu[3] = '0;
    a2 = {32'd2, 32'd1}; b2 = {32'd7, 32'd5}; lv2 = 1'b1;
    tick();
    lv2 = 1'b0; st2 = 1'b1;
    tick();
    st2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vec_cnt++;
      if ({lr2, clr2, busy2} !== 3'b100) begin
        err_cnt++;
        $display("FAIL n2_early_start: got %b want 100", {lr2, clr2, busy2});
      end
      tick();
    end
    a2 = {32'd4, 32'd3}; b2 = {32'd8, 32'd6}; lv2 = 1'b1; st2 = 1'b1;
    tick();
    lv2 = 1'b0; st2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vec_cnt++;
      if ({lr2, clr2, busy2, done2} !== 4'b0000) begin
        err_cnt++;
        $display("FAIL n2_ready_hold: got %b want 0000", {lr2, clr2, busy2, done2});
      end
      tick();
    end
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    for (int c = 0; c <= 3*N2 + LAT; c++) begin
      t  = c - 1 - LAT;
      el = (t >= 0 && t < 4) ? tl[t] : '0;
      eu = (t >= 0 && t < 4) ? tu[t] : '0;
      ec = {c >= 3*N2, c == LAT, c <= 3*N2 - 2 + LAT, c == 3*N2 - 1 + LAT};
      vec_cnt++;
      if (left2 !== el) begin
        err_cnt++;
        $display("FAIL n2_left c=%0d: got %h want %h", c, left2, el);
      end
      vec_cnt++;
      if (up2 !== eu) begin
        err_cnt++;
        $display("FAIL n2_up c=%0d: got %h want %h", c, up2, eu);
      end
      vec_cnt++;
      if ({lr2, clr2, busy2, done2} !== ec) begin
        err_cnt++;
        $display("FAIL n2_ctrl c=%0d: got %b want %b", c, {lr2, clr2, busy2, done2}, ec);
      end
      if (ec[0]) begin
        vec_cnt++;
        if ({acc00, acc01, acc10, acc11} !== {32'd19, 32'd22, 32'd43, 32'd50}) begin
          err_cnt++;
          $display("FAIL n2_grid: got %0d %0d %0d %0d want 19 22 43 50", acc00, acc01, acc10, acc11);
        end
      end
      lv2 = (c <= 3*N2 - 2);
      a2  = {$urandom(), $urandom()};
      b2  = {$urandom(), $urandom()};
      tick();
    end
    lv2 = 1'b0;
  endtask

  task automatic test_stream_n4();
    logic [N4*DW-1:0] el, eu;
    logic [3:0]       ec;
    int               t;
    for (int i = 0; i < N4; i++) begin
      for (int j = 0; j < N4; j++) begin
        ma[i][j] = $urandom();
        mb[i][j] = $urandom();
      end
    end
    vec_cnt++;
    if (lr4 !== 1'b1) begin
      err_cnt++;
      $display("FAIL n4_ready_before_load: got %b want 1", lr4);
    end
    load4();
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    for (int c = 0; c <= 3*N4 + LAT; c++) begin
      t  = c - 1 - LAT;
      el = '0;
      eu = '0;
      for (int r = 0; r < N4; r++) begin
        if (t >= 0 && t <= 3*N4 - 3 && t - r >= 0 && t - r < N4) begin
          el[r*DW +: DW] = ma[r][t-r];
          eu[r*DW +: DW] = mb[t-r][r];
        end
      end
      ec = {c >= 3*N4, c == LAT, c <= 3*N4 - 2 + LAT, c == 3*N4 - 1 + LAT};
      vec_cnt++;
      if (left4 !== el) begin
        err_cnt++;
        $display("FAIL n4_left c=%0d: got %h want %h", c, left4, el);
      end
      vec_cnt++;
      if (up4 !== eu) begin
        err_cnt++;
        $display("FAIL n4_up c=%0d: got %h want %h", c, up4, eu);
      end
      vec_cnt++;
      if ({lr4, clr4, busy4, done4} !== ec) begin
        err_cnt++;
        $display("FAIL n4_ctrl c=%0d: got %b want %b", c, {lr4, clr4, busy4, done4}, ec);
      end
      lv4 = (c <= 3*N4 - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      st4 = (c <= 3*N4 - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      a4  = {$urandom(), $urandom(), $urandom(), $urandom()};
      b4  = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    lv4 = 1'b0;
    st4 = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    for (int i = 0; i < N4; i++) begin
      for (int j = 0; j < N4; j++) begin
        ma[i][j] = $urandom() | 32'd1;
        mb[i][j] = $urandom() | 32'd1;
      end
    end
    load4();
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({lr4, clr4, busy4, done4} !== 4'b1000) begin
      err_cnt++;
      $display("FAIL rst_mid_ctrl: got %b want 1000", {lr4, clr4, busy4, done4});
    end
    vec_cnt++;
    if ({left4, up4} !== '0) begin
      err_cnt++;
      $display("FAIL rst_mid_lanes: got %h want 0", {left4, up4});
    end
    tick();
    rst = 1'b0;
    st4 = 1'b1;
    tick();
    st4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if ({lr4, clr4, busy4, done4, left4, up4} !== {4'b1000, {2*N4*DW{1'b0}}}) begin
        err_cnt++;
        $display("FAIL rst_idle_start_ignored: got %b want 1000", {lr4, clr4, busy4, done4});
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    a4 = '0; b4 = '0; lv4 = 1'b0; st4 = 1'b0;
    a2 = '0; b2 = '0; lv2 = 1'b0; st2 = 1'b0;
    #12;
    test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    test_directed_n2();
    test_stream_n4();
    test_stream_n4();
    test_reset_mid_stream();
    test_stream_n4();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
